// File: rtl/stg_ma_mem_resp.sv
// rtl/stg_ma_mem_resp.sv - MA ping-pong address responder with self-clearing local data RAM
module stg_ma_mem_resp #(
  parameter int ADDR_W     = 24,
  parameter int DATA_W     = 24,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic              iw_clk,
  input  logic              iw_rst,
  input  logic              iw_mem_mp,
  input  logic [ADDR_W-1:0] iw_mem_addr0,
  input  logic [ADDR_W-1:0] iw_mem_addr1,
  input  logic              iw_mem_req,
  input  logic              iw_mem_we,
  input  logic [DATA_W-1:0] iw_mem_wdata,
  output logic              ow_mem_ready,
  output logic [DATA_W-1:0] ow_mem_rdata,
  output logic              ow_mem_rvalid,
  output logic              ow_mem_err,
  output logic              ow_sync_err
);

  localparam int                  DEPTH    = 1 << DEPTH_LOG2;
  // Counter carries one spare bit so the last-word compare never aliases to zero.
  localparam logic [DEPTH_LOG2:0] CNT_LAST = (DEPTH_LOG2 + 1)'(DEPTH - 1);

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_e;

  state_e              state_q, state_d;
  logic [DEPTH_LOG2:0] cnt_q, cnt_d;
  logic                r_mp_q;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
  logic                err_q, err_d;
  logic                sync_err_q, sync_err_d;

  logic [DATA_W-1:0]     ram_q [DEPTH];
  logic                  ram_we;
  logic [DEPTH_LOG2-1:0] ram_waddr;
  logic [DATA_W-1:0]     ram_wdata;

  logic [ADDR_W-1:0]     addr;
  logic                  in_range;
  logic [DEPTH_LOG2-1:0] idx;

  // MA presents the live address on port 0 in phase 1 and on port 1 in phase 0.
  assign addr     = iw_mem_mp ? iw_mem_addr0 : iw_mem_addr1;
  assign in_range = (addr >> DEPTH_LOG2) == '0;
  assign idx      = addr[DEPTH_LOG2-1:0];

  // Next-state: clear sweep, request decode, response and error flags.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    rvalid_d   = 1'b0;
    err_d      = 1'b0;
    sync_err_d = sync_err_q;
    ram_we     = 1'b0;
    ram_waddr  = idx;
    ram_wdata  = iw_mem_wdata;
    case (state_q)
      ST_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = cnt_q[DEPTH_LOG2-1:0];
        ram_wdata = '0;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
        end
        // Traffic is refused until the RAM is fully cleared.
        if (iw_mem_req) begin
          err_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (iw_mem_req) begin
          // A phase slip is flagged but the request is still served as sampled.
          if (iw_mem_mp != r_mp_q) begin
            sync_err_d = 1'b1;
          end
          if (!in_range) begin
            rdata_d = '0;
            err_d   = 1'b1;
          end else if (iw_mem_we) begin
            ram_we = 1'b1;
          end else begin
            rdata_d  = ram_q[idx];
            rvalid_d = 1'b1;
          end
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  // Control and response registers; reset restarts the clear sweep from word 0.
  always_ff @(posedge iw_clk or posedge iw_rst) begin
    if (iw_rst) begin
      state_q    <= ST_CLEAR;
      cnt_q      <= '0;
      r_mp_q     <= 1'b0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      sync_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      r_mp_q     <= ~r_mp_q;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      err_q      <= err_d;
      sync_err_q <= sync_err_d;
    end
  end

  // RAM array has no reset; its contents are established by the clear sweep.
  always_ff @(posedge iw_clk) begin
    if (ram_we) begin
      ram_q[ram_waddr] <= ram_wdata;
    end
  end

  assign ow_mem_ready  = (state_q == ST_RUN);
  assign ow_mem_rdata  = rdata_q;
  assign ow_mem_rvalid = rvalid_q;
  assign ow_mem_err    = err_q;
  assign ow_sync_err   = sync_err_q;

endmodule

// File: tb/tb_stg_ma_mem_resp.sv
// tb/tb_stg_ma_mem_resp.sv - randomized model-checked bench for stg_ma_mem_resp
module tb_stg_ma_mem_resp;

  localparam int AW    = 24;
  localparam int DW    = 24;
  localparam int DL    = 4;
  localparam int DEPTH = 1 << DL;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          mp = 1'b0;
  logic          req = 1'b0;
  logic          we = 1'b0;
  logic [AW-1:0] a0 = '0;
  logic [AW-1:0] a1 = '0;
  logic [DW-1:0] wd = '0;
  logic          ready;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          err;
  logic          serr;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  stg_ma_mem_resp #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .DEPTH_LOG2(DL)
  ) dut (
    .iw_clk(clk),
    .iw_rst(rst),
    .iw_mem_mp(mp),
    .iw_mem_addr0(a0),
    .iw_mem_addr1(a1),
    .iw_mem_req(req),
    .iw_mem_we(we),
    .iw_mem_wdata(wd),
    .ow_mem_ready(ready),
    .ow_mem_rdata(rdata),
    .ow_mem_rvalid(rvalid),
    .ow_mem_err(err),
    .ow_sync_err(serr)
  );

  // Behavioural model: edges since reset decide CLEAR vs RUN; memory is a plain array.
  int            m_edges;
  bit            m_phase;
  logic [DW-1:0] m_rdata;
  bit            m_rvalid;
  bit            m_err;
  bit            m_sync;
  logic [DW-1:0] m_mem [DEPTH];
  logic [AW-1:0] m_a;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_edges  = 0;
    m_phase  = 1'b0;
    m_rdata  = '0;
    m_rvalid = 1'b0;
    m_err    = 1'b0;
    m_sync   = 1'b0;
  endtask

  task automatic model_step();
    m_rvalid = 1'b0;
    m_err    = 1'b0;
    if (m_edges < DEPTH) begin
      if (req) m_err = 1'b1;
      if (m_edges == DEPTH - 1) begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      end
      m_edges++;
    end else if (req) begin
      if (mp != m_phase) m_sync = 1'b1;
      m_a = mp ? a0 : a1;
      if (m_a >= AW'(DEPTH)) begin
        m_rdata = '0;
        m_err   = 1'b1;
      end else if (we) begin
        m_mem[m_a[DL-1:0]] = wd;
      end else begin
        m_rdata  = m_mem[m_a[DL-1:0]];
        m_rvalid = 1'b1;
      end
    end
    m_phase = ~m_phase;
  endtask

  // One clock: model follows the same edge, inputs may change 2 time units later.
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #2;
  endtask

  // Single compare process: every output against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cmp_ready", 32'(ready), 32'(m_edges >= DEPTH));
      chk("cmp_rvalid", 32'(rvalid), 32'(m_rvalid));
      chk("cmp_err", 32'(err), 32'(m_err));
      chk("cmp_sync_err", 32'(serr), 32'(m_sync));
      chk("cmp_rdata", 32'(rdata), 32'(m_rdata));
    end
  end

  // Request on the port selected by the current phase (optionally with a slipped phase bit).
  task automatic op(input bit w, input logic [AW-1:0] ad, input logic [DW-1:0] d, input bit slip);
    mp  = m_phase ^ slip;
    req = 1'b1;
    we  = w;
    wd  = d;
    if (mp) begin
      a0 = ad;
      a1 = AW'($urandom);
    end else begin
      a1 = ad;
      a0 = AW'($urandom);
    end
    tick();
    req = 1'b0;
    we  = 1'b0;
  endtask

  // Request with both ports driven explicitly, issued when the local phase equals mpv.
  task automatic op2(input bit w, input logic [AW-1:0] p0, input logic [AW-1:0] p1,
                     input logic [DW-1:0] d, input bit mpv);
    for (int k = 0; k < 4 && m_phase != mpv; k++) tick();
    mp  = mpv;
    req = 1'b1;
    we  = w;
    a0  = p0;
    a1  = p1;
    wd  = d;
    tick();
    req = 1'b0;
    we  = 1'b0;
  endtask

  task automatic do_reset(input int hold);
    #1;
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_sync_err", 32'(serr), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    for (int k = 0; k < hold; k++) tick();
    rst = 1'b0;
  endtask

  // Counts clock edges from reset release until ready, with random requests during CLEAR.
  task automatic measure_clear(input string nm);
    int n;
    for (n = 1; n <= 100; n++) begin
      req = 1'($urandom);
      we  = 1'($urandom);
      mp  = m_phase;
      a0  = AW'($urandom_range(0, DEPTH - 1));
      a1  = AW'($urandom_range(0, DEPTH - 1));
      wd  = DW'($urandom);
      tick();
      if (ready) break;
    end
    req = 1'b0;
    we  = 1'b0;
    chk(nm, 32'(n), 32'(DEPTH));
  endtask

  task automatic random_traffic(input int n);
    logic [AW-1:0] ad;
    int r;
    for (int i = 0; i < n; i++) begin
      r = $urandom_range(0, 9);
      if (r < 2) begin
        tick();
      end else begin
        if (r == 9) ad = AW'($urandom_range(DEPTH, 2 * DEPTH));
        else if (r == 8) ad = AW'($urandom) | AW'(DEPTH);
        else ad = AW'($urandom_range(0, DEPTH - 1));
        op(1'($urandom), ad, DW'($urandom), 1'b0);
      end
    end
  endtask

  initial begin
    #1;
    rst = 1'b1;
    model_reset();
    chk_en = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // T1: CLEAR lasts DEPTH edges, then every word reads back as zero.
    for (int i = 1; i <= DEPTH; i++) begin
      tick();
      if (i == 8) chk("t1_rvalid_in_clear", 32'(rvalid), 32'd0);
      if (i == DEPTH - 1) chk("t1_ready_low", 32'(ready), 32'd0);
      if (i == DEPTH) chk("t1_ready_high", 32'(ready), 32'd1);
    end
    for (int w = 0; w < DEPTH; w++) begin
      op(1'b0, AW'(w), '0, 1'b0);
      chk("t1_read_zero", 32'(rdata), 32'd0);
      chk("t1_read_valid", 32'(rvalid), 32'd1);
    end

    // T2: write via port 0, read back via port 1 on the very next cycle.
    op2(1'b1, AW'(5), AW'(0), 24'hABCDEF, 1'b1);
    chk("t2_write_rvalid", 32'(rvalid), 32'd0);
    op2(1'b0, AW'(0), AW'(5), '0, 1'b0);
    chk("t2_rdata", 32'(rdata), 32'hABCDEF);
    chk("t2_rvalid", 32'(rvalid), 32'd1);
    tick();
    chk("t2_rvalid_one_cycle", 32'(rvalid), 32'd0);
    chk("t2_rdata_hold", 32'(rdata), 32'hABCDEF);

    // T3: phase bit picks the port.
    op(1'b1, AW'(7), 24'h000011, 1'b0);
    op(1'b1, AW'(9), 24'h000022, 1'b0);
    op2(1'b0, AW'(7), AW'(9), '0, 1'b1);
    chk("t3_port0", 32'(rdata), 32'h11);
    op2(1'b0, AW'(7), AW'(9), '0, 1'b0);
    chk("t3_port1", 32'(rdata), 32'h22);

    // T4: out-of-range requests are rejected and leave the RAM untouched.
    op(1'b0, AW'(24'h000400), '0, 1'b0);
    chk("t4_err", 32'(err), 32'd1);
    chk("t4_rvalid", 32'(rvalid), 32'd0);
    chk("t4_rdata", 32'(rdata), 32'd0);
    tick();
    chk("t4_err_pulse", 32'(err), 32'd0);
    op(1'b1, AW'(DEPTH + 5), 24'h5A5A5A, 1'b0);
    chk("t4_boundary_err", 32'(err), 32'd1);
    op(1'b0, AW'(DEPTH - 1), '0, 1'b0);
    chk("t4_last_word_ok", 32'(err), 32'd0);
    op(1'b0, AW'(5), '0, 1'b0);
    chk("t4_ram_unchanged", 32'(rdata), 32'hABCDEF);

    random_traffic(400);

    // T5: three in-phase requests, then one slipped request sets a sticky error.
    for (int i = 0; i < 3; i++) op(1'b0, AW'(i), '0, 1'b0);
    chk("t5_sync_clean", 32'(serr), 32'd0);
    op(1'b0, AW'(5), '0, 1'b1);
    chk("t5_sync_set", 32'(serr), 32'd1);
    random_traffic(20);
    chk("t5_sync_sticky", 32'(serr), 32'd1);

    // T6: reset mid-CLEAR and mid-RUN both restart a full-length clear.
    do_reset(2);
    for (int i = 0; i < 7; i++) tick();
    do_reset(1);
    measure_clear("t6_clear_len_after_clear_abort");
    op(1'b1, AW'(3), 24'h333333, 1'b0);
    random_traffic(50);
    req = 1'b1;
    do_reset(3);
    measure_clear("t6_clear_len_after_run_abort");
    op(1'b0, AW'(3), '0, 1'b0);
    chk("t6_word_cleared", 32'(rdata), 32'd0);
    random_traffic(100);

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
